// File: rtl/hdmi_island_pkg.sv
// Shared types and constants for the HDMI island scheduler.
// Build option: HDMI_ISLAND_RR_EN selects round-robin arbitration (default: fixed priority).
package hdmi_island_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_LEAD_GUARD,
    S_PACKET,
    S_TRAIL_GUARD
  } island_state_t;

  localparam int PREAMBLE_LEN = 8;
  localparam int GUARD_LEN    = 2;
  localparam int PACKET_LEN   = 32;
  localparam int ISLAND_LEN   = PREAMBLE_LEN + 2 * GUARD_LEN + PACKET_LEN;

  localparam logic [3:0] CTL_VIDEO  = 4'b0001;
  localparam logic [3:0] CTL_ISLAND = 4'b0101;

  // Terminal count of a phase that lasts len cycles.
  function automatic logic [4:0] last_cnt(input int len);
    return 5'(len - 1);
  endfunction

endpackage

// File: rtl/hdmi_rr_arbiter.sv
// One-hot packet-source arbiter. With HDMI_ISLAND_RR_EN defined the search starts at a
// pointer that moves past the granted requester on each advance strobe; otherwise lowest index wins.
module hdmi_rr_arbiter #(
  parameter int NUM_REQ = 2
) (
`ifdef HDMI_ISLAND_RR_EN
  input  logic               clk,
  input  logic               reset,
  input  logic               advance,
  input  logic [NUM_REQ-1:0] owner,
`endif
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant
);

`ifdef HDMI_ISLAND_RR_EN
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]          ptr;
  logic [PW-1:0]          next_ptr;
  logic [2*NUM_REQ-1:0]   req_dbl;
  logic [2*NUM_REQ-1:0]   gnt_dbl;
  logic [NUM_REQ-1:0]     req_rot;
  logic [NUM_REQ-1:0]     gnt_rot;

  // Rotate so the pointer sits at bit 0, pick the lowest bit, rotate back.
  assign req_dbl = {req, req} >> ptr;
  assign req_rot = req_dbl[NUM_REQ-1:0];
  assign gnt_rot = req_rot & (~req_rot + NUM_REQ'(1));
  assign gnt_dbl = {gnt_rot, gnt_rot} << ptr;
  assign grant   = gnt_dbl[2*NUM_REQ-1:NUM_REQ];

  always_comb begin
    next_ptr = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner[i]) next_ptr = (i == NUM_REQ - 1) ? '0 : PW'(i + 1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        ptr <= '0;
    else if (advance) ptr <= next_ptr;
  end
`else
  assign grant = req & (~req + NUM_REQ'(1));
`endif

endmodule

// File: rtl/hdmi_island_scheduler.sv
// Schedules video preamble/guard and one 44-cycle data island per line on the pixel clock.
// Build option: HDMI_ISLAND_RR_EN selects round-robin packet arbitration.
module hdmi_island_scheduler #(
  parameter int NUM_REQ        = 2,
  parameter int H_TOTAL        = 858,
  parameter int H_ACTIVE_START = 60,
  parameter int ISLAND_HPOS    = 782
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [9:0]         hpos,
  input  logic               in_hblank,
  input  logic               in_vblank,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic               ack,
  output logic               preamble,
  output logic [3:0]         ctl,
  output logic               guard_video,
  output logic               guard_island,
  output logic               in_island_data,
  output logic [4:0]         packet_cycle,
  output logic               error
);
  import hdmi_island_pkg::*;

  if (ISLAND_HPOS + ISLAND_LEN > H_TOTAL) begin : g_bad_island_pos
    $error("island does not fit in the line");
  end
  if (H_ACTIVE_START < 10) begin : g_bad_active_start
    $error("H_ACTIVE_START must leave room for the video preamble");
  end
  if (NUM_REQ < 1 || NUM_REQ > 8) begin : g_bad_num_req
    $error("NUM_REQ must be 1..8");
  end

  localparam logic [9:0] ISL_POS  = 10'(ISLAND_HPOS);
  localparam logic [9:0] VP_FIRST = 10'(H_ACTIVE_START - 10);
  localparam logic [9:0] VP_LAST  = 10'(H_ACTIVE_START - 3);
  localparam logic [9:0] VG_FIRST = 10'(H_ACTIVE_START - 2);
  localparam logic [9:0] VG_LAST  = 10'(H_ACTIVE_START - 1);

  island_state_t      state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [NUM_REQ-1:0] arb_grant;
  logic               start, abort, island_d, video_pre, video_guard, overlap;

  hdmi_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
`ifdef HDMI_ISLAND_RR_EN
    .clk     (clk),
    .reset   (reset),
    .advance (ack),
    .owner   (grant),
`endif
    .req     (req),
    .grant   (arb_grant)
  );

  assign start = (state_q == S_IDLE) && (hpos == ISL_POS) && enable && in_hblank && (|req);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    abort   = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_PREAMBLE;
        cnt_d   = '0;
      end
      S_PREAMBLE: if (cnt_q == last_cnt(PREAMBLE_LEN)) begin
        state_d = S_LEAD_GUARD;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 5'd1;
      S_LEAD_GUARD: if (cnt_q == last_cnt(GUARD_LEN)) begin
        state_d = S_PACKET;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 5'd1;
      S_PACKET: if (cnt_q == last_cnt(PACKET_LEN)) begin
        state_d = S_TRAIL_GUARD;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 5'd1;
      S_TRAIL_GUARD: if (cnt_q == last_cnt(GUARD_LEN)) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 5'd1;
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Losing blanking mid-island kills the island outright; no ack is issued.
    if (state_q != S_IDLE && !in_hblank) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      abort   = 1'b1;
    end
  end

  assign island_d    = (state_d != S_IDLE);
  assign video_pre   = !in_vblank && (hpos >= VP_FIRST) && (hpos <= VP_LAST);
  assign video_guard = !in_vblank && (hpos >= VG_FIRST) && (hpos <= VG_LAST);
  assign overlap     = island_d && (video_pre || video_guard);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are registered from next-state so they line up with hpos one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant          <= '0;
      ack            <= 1'b0;
      preamble       <= 1'b0;
      ctl            <= '0;
      guard_video    <= 1'b0;
      guard_island   <= 1'b0;
      in_island_data <= 1'b0;
      packet_cycle   <= '0;
      error          <= 1'b0;
    end else begin
      grant          <= !island_d ? '0 : (state_q == S_IDLE) ? arb_grant : grant;
      ack            <= (state_d == S_PACKET) && (cnt_d == last_cnt(PACKET_LEN));
      preamble       <= (state_d == S_PREAMBLE) || (video_pre && !island_d);
      ctl            <= (state_d == S_PREAMBLE)    ? CTL_ISLAND :
                        (video_pre && !island_d)   ? CTL_VIDEO  : 4'b0000;
      guard_video    <= video_guard && !island_d;
      guard_island   <= (state_d == S_LEAD_GUARD) || (state_d == S_TRAIL_GUARD);
      in_island_data <= (state_d == S_PACKET);
      packet_cycle   <= (state_d == S_PACKET) ? cnt_d : 5'd0;
      error          <= error | abort | overlap;
    end
  end

endmodule

// File: tb/tb_hdmi_island_scheduler.sv
// Line-level bench for hdmi_island_scheduler: drives whole lines and compares every cycle
// against an offset-based model of the island/preamble schedule.
module tb_hdmi_island_scheduler;
  localparam int NUM_REQ        = 2;
  localparam int H_TOTAL        = 858;
  localparam int H_ACTIVE_START = 60;
  localparam int ISLAND_HPOS    = 782;
  localparam int HB_START       = 780;
  localparam int OW             = NUM_REQ + 15;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic               enable;
  logic [9:0]         hpos;
  logic               in_hblank;
  logic               in_vblank;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic               ack;
  logic               preamble;
  logic [3:0]         ctl;
  logic               guard_video;
  logic               guard_island;
  logic               in_island_data;
  logic [4:0]         packet_cycle;
  logic               error;

  hdmi_island_scheduler #(
    .NUM_REQ(NUM_REQ), .H_TOTAL(H_TOTAL),
    .H_ACTIVE_START(H_ACTIVE_START), .ISLAND_HPOS(ISLAND_HPOS)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .hpos(hpos),
    .in_hblank(in_hblank), .in_vblank(in_vblank), .req(req),
    .grant(grant), .ack(ack), .preamble(preamble), .ctl(ctl),
    .guard_video(guard_video), .guard_island(guard_island),
    .in_island_data(in_island_data), .packet_cycle(packet_cycle), .error(error)
  );

  logic [OW-1:0] obs_v;
  assign obs_v = {grant, ack, preamble, ctl, guard_video, guard_island,
                  in_island_data, packet_cycle, error};

  // scoreboard
  logic [OW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int last_h = 0;

  // reference model: island expressed as an offset from its start hpos
  bit alive = 1'b0;
  int off   = 0;
  int owner = 0;
  int ptr   = 0;
  bit err_m = 1'b0;

  function automatic int pick(input logic [NUM_REQ-1:0] r);
    int k;
    for (int i = 0; i < NUM_REQ; i++) begin
`ifdef HDMI_ISLAND_RR_EN
      k = (ptr + i) % NUM_REQ;
`else
      k = i;
`endif
      if (r[k]) return k;
    end
    return 0;
  endfunction

  task automatic model_step(input int h, input bit hb, input bit vb, input bit en,
                            input logic [NUM_REQ-1:0] r);
    bit vp, vg, ipre, igrd, idat, ak;
    logic [3:0] c;
    logic [4:0] pc;
    logic [NUM_REQ-1:0] g;
    if (alive && !hb) begin
      alive = 1'b0;
      err_m = 1'b1;
    end else if (alive) begin
      off++;
      if (off == 44) alive = 1'b0;
    end else if (h == ISLAND_HPOS && en && hb && (r != '0)) begin
      alive = 1'b1;
      off   = 0;
      owner = pick(r);
    end
    vp = !vb && h >= H_ACTIVE_START - 10 && h <= H_ACTIVE_START - 3;
    vg = !vb && h >= H_ACTIVE_START - 2 && h <= H_ACTIVE_START - 1;
    if (alive && (vp || vg)) begin
      err_m = 1'b1;
      vp = 1'b0;
      vg = 1'b0;
    end
    ipre = alive && off < 8;
    igrd = alive && ((off >= 8 && off < 10) || off >= 42);
    idat = alive && off >= 10 && off < 42;
    ak   = alive && off == 41;
`ifdef HDMI_ISLAND_RR_EN
    if (ak) ptr = (owner + 1) % NUM_REQ;
`endif
    g  = alive ? (NUM_REQ'(1) << owner) : '0;
    c  = ipre ? 4'b0101 : vp ? 4'b0001 : 4'b0000;
    pc = idat ? 5'(off - 10) : 5'd0;
    exp_q.push_back({g, ak, ipre || vp, c, vg, igrd, idat, pc, err_m});
  endtask

  task automatic check_out(input string tag);
    logic [OW-1:0] e;
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    checks++;
    assert (obs_v === e) else begin
      errors++;
      $error("FAIL %s hpos=%0d observed=%h expected=%h", tag, last_h, obs_v, e);
    end
  endtask

  // driver: one full line; abort_h forces in_hblank low, rst_h pulses reset
  task automatic run_line(input string tag, input bit en, input logic [NUM_REQ-1:0] r,
                          input bit vb, input int abort_h, input int rst_h, input bit rnd_req);
    bit hb;
    logic [NUM_REQ-1:0] rc;
    for (int h = 0; h < H_TOTAL; h++) begin
      @(negedge clk);
      check_out(tag);
      if (h == rst_h) begin
        reset = 1'b1;
        #1;
        checks++;
        assert (obs_v === '0) else begin
          errors++;
          $error("FAIL %s_async_reset observed=%h expected=0", tag, obs_v);
        end
        exp_q.delete();
        alive = 1'b0;
        off   = 0;
        err_m = 1'b0;
        ptr   = 0;
        reset = 1'b0;
      end
      hb = (h < H_ACTIVE_START || h >= HB_START) && (h != abort_h);
      rc = rnd_req ? NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1)) : r;
      hpos      = 10'(h);
      in_hblank = hb;
      in_vblank = vb;
      enable    = en;
      req       = rc;
      last_h    = h;
      model_step(h, hb, vb, en, rc);
    end
  endtask

  initial begin
    bit en, vb;
    int ab;
    logic [NUM_REQ-1:0] r;
    reset = 1'b1; enable = 1'b0; hpos = '0; in_hblank = 1'b0; in_vblank = 1'b0; req = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    assert (obs_v === '0) else begin
      errors++;
      $error("FAIL reset_state observed=%h expected=0", obs_v);
    end

    run_line("basic_req01", 1'b1, 2'b01, 1'b0, -1, -1, 1'b0);
    run_line("arb_line1",   1'b1, 2'b11, 1'b0, -1, -1, 1'b0);
    run_line("arb_line2",   1'b1, 2'b11, 1'b0, -1, -1, 1'b0);
    run_line("arb_line3",   1'b1, 2'b11, 1'b0, -1, -1, 1'b0);
    run_line("vblank_line", 1'b1, 2'b10, 1'b1, -1, -1, 1'b0);
    run_line("hblank_abort", 1'b1, 2'b01, 1'b0, 800, -1, 1'b0);
    run_line("error_sticky", 1'b1, 2'b10, 1'b0, -1, -1, 1'b0);
    run_line("reset_mid_packet", 1'b1, 2'b10, 1'b0, -1, ISLAND_HPOS + 28, 1'b0);
    run_line("after_reset", 1'b1, 2'b11, 1'b0, -1, -1, 1'b0);
    run_line("enable_off",  1'b0, 2'b10, 1'b0, -1, -1, 1'b0);

    for (int n = 0; n < 6; n++) begin
      en = ($urandom_range(0, 3) != 0);
      vb = 1'($urandom_range(0, 1));
      r  = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(ISLAND_HPOS + 1, ISLAND_HPOS + 44)) : -1;
      run_line("random_line", en, r, vb, ab, -1, 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    check_out("drain");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
